// File: rtl/ahb_pkg.sv
// ahb_pkg
//   Shared AHB encodings and the burst-sequencer state type used by
//   ahb_burst_interface and its FSM sub-block.
//   Contents: HTRANS/HBURST codes, burst_state_e, hburst_for() which maps a
//   beat count onto its INCRx burst code.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    // IDLE : no transfer outstanding
    // ADDR : burst address phases still to be issued
    // DATA : last data phase in progress
    // DONE : transfer finished, requester still stalled
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } burst_state_e;

    function automatic logic [2:0] hburst_for(input int beats);
        case (beats)
            4:       return HBURST_INCR4;
            8:       return HBURST_INCR8;
            16:      return HBURST_INCR16;
            default: return HBURST_SINGLE;
        endcase
    endfunction

endpackage

// File: rtl/ahb_burst_fsm.sv
// ahb_burst_fsm
//   Burst sequencer: state register, address/data beat counters and the
//   control outputs that depend only on sequencing.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     hready          AHB subordinate ready
//     req             legal request present and not flushed
//     req_burst       request wants a multi-beat burst
//     stall           requester pipeline stalled
//     state           current sequencer state
//     adr_beat        number of address phases accepted (address-phase index)
//     data_beat       index of the data phase currently in progress
//     htrans          AHB HTRANS
//     bus_stall       transfer in flight towards the requester
//     bus_committed   transfer issued and no longer cancellable
//     addr_accept     an address phase completes this cycle
//     data_accept     a data phase completes this cycle
//     burst_active    latched burst flag of the transfer in flight
module ahb_burst_fsm
    import ahb_pkg::*;
#(
    parameter int BEATS = 4,
    parameter int BW    = $clog2(BEATS) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hready,
    input  logic          req,
    input  logic          req_burst,
    input  logic          stall,
    output burst_state_e  state,
    output logic [BW-1:0] adr_beat,
    output logic [BW-1:0] data_beat,
    output logic [1:0]    htrans,
    output logic          bus_stall,
    output logic          bus_committed,
    output logic          addr_accept,
    output logic          data_accept,
    output logic          burst_active
);

    burst_state_e  state_q, state_d;
    logic [BW-1:0] adr_q, adr_d;
    logic [BW-1:0] dat_q, dat_d;
    logic          burst_q, burst_d;

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        burst_d     = burst_q;
        htrans      = HTRANS_IDLE;
        addr_accept = 1'b0;
        data_accept = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // NONSEQ is offered combinationally so a request costs no
                // extra cycle; it is held until HREADY takes it.
                if (req) begin
                    htrans = HTRANS_NONSEQ;
                    if (hready) begin
                        addr_accept = 1'b1;
                        adr_d       = BW'(1);
                        dat_d       = '0;
                        burst_d     = req_burst;
                        state_d     = req_burst ? ST_ADDR : ST_DATA;
                    end
                end
            end
            ST_ADDR: begin
                htrans = HTRANS_SEQ;
                // Each accepted SEQ also retires the previous data phase.
                if (hready) begin
                    addr_accept = 1'b1;
                    data_accept = 1'b1;
                    adr_d       = adr_q + BW'(1);
                    dat_d       = dat_q + BW'(1);
                    if (adr_q == BW'(BEATS - 1)) begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (hready) begin
                    data_accept = 1'b1;
                    adr_d       = '0;
                    dat_d       = '0;
                    burst_d     = 1'b0;
                    // Parking in DONE keeps a still-asserted request from
                    // being issued a second time while the requester stalls.
                    state_d     = stall ? ST_DONE : ST_IDLE;
                end
            end
            ST_DONE: begin
                if (!stall) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            burst_q <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            burst_q <= burst_d;
        end
    end

    assign state         = state_q;
    assign adr_beat      = adr_q;
    assign data_beat     = dat_q;
    assign burst_active  = burst_q;
    assign bus_committed = (state_q == ST_ADDR) || (state_q == ST_DATA);
    // Released in the cycle the last data phase completes so the requester
    // can advance in step with the bus; DONE is not a stall.
    assign bus_stall     = (state_q == ST_ADDR)
                         || ((state_q == ST_DATA) && !hready)
                         || ((state_q == ST_IDLE) && req);

endmodule

// File: rtl/ahb_burst_interface.sv
// ahb_burst_interface
//   AHB manager front-end: turns a BusRW request into a SINGLE or BEATS-beat
//   INCR burst and gathers read beats into a line-wide fetch buffer.
//   Ports:
//     HCLK, HRESET          clock, synchronous active-high reset
//     HREADY, HRDATA        AHB subordinate ready / read data
//     HADDR, HTRANS, HWRITE,
//     HBURST, HSIZE         AHB address-phase signals (zero while HTRANS=IDLE)
//     HWDATA, HWSTRB        AHB data-phase write data / strobes
//     Stall, Flush          requester stalled / cancel unissued request
//     BusRW, Burst, Addr,
//     Size, ByteMask        request: 10 read, 01 write; burst or single
//     WriteData, WriteBeat  requester supplies WriteData for beat WriteBeat
//     FetchBuffer           read beats, beat k at [k*AHBW +: AHBW]
//     BusStall, BusCommitted  transfer in flight / no longer cancellable
module ahb_burst_interface
    import ahb_pkg::*;
#(
    parameter int AHBW    = 64,
    parameter int PA_BITS = 56,
    parameter int BEATS   = 4
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      HREADY,
    input  logic [AHBW-1:0]           HRDATA,
    output logic [PA_BITS-1:0]        HADDR,
    output logic [1:0]                HTRANS,
    output logic                      HWRITE,
    output logic [2:0]                HBURST,
    output logic [2:0]                HSIZE,
    output logic [AHBW-1:0]           HWDATA,
    output logic [AHBW/8-1:0]         HWSTRB,
    input  logic                      Stall,
    input  logic                      Flush,
    input  logic [1:0]                BusRW,
    input  logic                      Burst,
    input  logic [PA_BITS-1:0]        Addr,
    input  logic [2:0]                Size,
    input  logic [AHBW/8-1:0]         ByteMask,
    input  logic [AHBW-1:0]           WriteData,
    output logic [$clog2(BEATS):0]    WriteBeat,
    output logic [BEATS*AHBW-1:0]     FetchBuffer,
    output logic                      BusStall,
    output logic                      BusCommitted
);

    localparam int BW       = $clog2(BEATS) + 1;
    localparam int SZ_LOG2  = $clog2(AHBW / 8);
    localparam int LINE_L   = $clog2(BEATS * AHBW / 8);
    localparam bit BURST_OK = (BEATS > 1);
    localparam logic [PA_BITS-1:0] LINE_MASK =
        ~((PA_BITS'(1) << LINE_L) - PA_BITS'(1));

    burst_state_e  state;
    logic [BW-1:0] adr_beat, data_beat;
    logic [1:0]    htrans;
    logic          addr_accept, data_accept, burst_active;
    logic          req, req_burst, req_write;

    assign req       = ((BusRW == 2'b10) || (BusRW == 2'b01)) && !Flush;
    assign req_burst = Burst && BURST_OK;
    assign req_write = (BusRW == 2'b01);

    ahb_burst_fsm #(
        .BEATS (BEATS),
        .BW    (BW)
    ) u_fsm (
        .clk           (HCLK),
        .rst           (HRESET),
        .hready        (HREADY),
        .req           (req),
        .req_burst     (req_burst),
        .stall         (Stall),
        .state         (state),
        .adr_beat      (adr_beat),
        .data_beat     (data_beat),
        .htrans        (htrans),
        .bus_stall     (BusStall),
        .bus_committed (BusCommitted),
        .addr_accept   (addr_accept),
        .data_accept   (data_accept),
        .burst_active  (burst_active)
    );

    // Direction of the transfer in flight; the data phases need it after
    // BusRW may have been dropped.
    logic write_q, write_d;
    logic [AHBW-1:0]           hwdata_q, hwdata_d;
    logic [AHBW/8-1:0]         hwstrb_q, hwstrb_d;
    logic [BEATS-1:0][AHBW-1:0] fb_q, fb_d;

    logic cur_burst, cur_write, addr_phase;
    logic [PA_BITS-1:0] burst_addr;

    // In IDLE the address phase comes straight from the request; later
    // phases use what was latched when NONSEQ was accepted.
    assign cur_burst  = (state == ST_IDLE) ? req_burst : burst_active;
    assign cur_write  = (state == ST_IDLE) ? req_write : write_q;
    assign addr_phase = (htrans != HTRANS_IDLE);

    // Line-aligned start plus beat offset: an INCR burst of a full line
    // never crosses a line, hence never a 1KB boundary.
    assign burst_addr = (Addr & LINE_MASK) | (PA_BITS'(adr_beat) << SZ_LOG2);

    always_comb begin
        write_d  = write_q;
        hwdata_d = hwdata_q;
        hwstrb_d = hwstrb_q;
        fb_d     = fb_q;

        if ((state == ST_IDLE) && addr_accept) begin
            write_d = req_write;
        end

        // Write data lags its address phase by one cycle and must stay put
        // through wait states, so it only moves when an address is taken.
        if (addr_accept) begin
            hwdata_d = WriteData;
            hwstrb_d = cur_burst ? '1 : ByteMask;
        end

        if (data_accept && !write_q) begin
            for (int k = 0; k < BEATS; k++) begin
                if (data_beat == BW'(k)) begin
                    fb_d[k] = HRDATA;
                end
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            write_q  <= 1'b0;
            hwdata_q <= '0;
            hwstrb_q <= '0;
            fb_q     <= '0;
        end else begin
            write_q  <= write_d;
            hwdata_q <= hwdata_d;
            hwstrb_q <= hwstrb_d;
            fb_q     <= fb_d;
        end
    end

    assign HTRANS      = htrans;
    assign HADDR       = !addr_phase ? '0 : (cur_burst ? burst_addr : Addr);
    assign HWRITE      = addr_phase && cur_write;
    assign HBURST      = !addr_phase ? HBURST_SINGLE
                       : (cur_burst ? hburst_for(BEATS) : HBURST_SINGLE);
    assign HSIZE       = !addr_phase ? 3'b000 : (cur_burst ? 3'(SZ_LOG2) : Size);
    assign HWDATA      = hwdata_q;
    assign HWSTRB      = hwstrb_q;
    assign WriteBeat   = adr_beat;
    assign FetchBuffer = fb_q;

endmodule

// File: tb/tb_ahb_burst_interface.sv
// Testbench for ahb_burst_interface (AHBW=64, PA_BITS=56, BEATS=4).
// A transaction-level model (beats issued / beats completed) predicts every
// output on each falling edge; directed sequences add literal expectations.
module tb_ahb_burst_interface;

    localparam int AHBW  = 64;
    localparam int PA    = 56;
    localparam int BEATS = 4;

    logic            HCLK = 1'b0;
    logic            HRESET, HREADY;
    logic [63:0]     HRDATA;
    logic [PA-1:0]   HADDR;
    logic [1:0]      HTRANS;
    logic            HWRITE;
    logic [2:0]      HBURST, HSIZE;
    logic [63:0]     HWDATA;
    logic [7:0]      HWSTRB;
    logic            Stall, Flush, Burst;
    logic [1:0]      BusRW;
    logic [PA-1:0]   Addr;
    logic [2:0]      Size;
    logic [7:0]      ByteMask;
    logic [63:0]     WriteData;
    logic [2:0]      WriteBeat;
    logic [255:0]    FetchBuffer;
    logic            BusStall, BusCommitted;

    always #5 HCLK = ~HCLK;

    ahb_burst_interface #(.AHBW(AHBW), .PA_BITS(PA), .BEATS(BEATS)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HREADY(HREADY), .HRDATA(HRDATA),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HBURST(HBURST),
        .HSIZE(HSIZE), .HWDATA(HWDATA), .HWSTRB(HWSTRB), .Stall(Stall),
        .Flush(Flush), .BusRW(BusRW), .Burst(Burst), .Addr(Addr), .Size(Size),
        .ByteMask(ByteMask), .WriteData(WriteData), .WriteBeat(WriteBeat),
        .FetchBuffer(FetchBuffer), .BusStall(BusStall), .BusCommitted(BusCommitted)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] wd(input int b);
        return {32'hBEEF_0000, 32'(b)};
    endfunction

    // ---------------- transaction-level model ----------------
    logic        m_busy, m_wait, m_wr, m_burst;
    int          m_n, m_iss, m_cmp;
    logic [63:0] m_fb [BEATS];
    logic [63:0] m_hwdata;
    logic [7:0]  m_hwstrb;

    function automatic logic m_req();
        return ((BusRW == 2'b10) || (BusRW == 2'b01)) && !Flush;
    endfunction

    always @(posedge HCLK) begin
        if (HRESET) begin
            m_busy <= 1'b0; m_wait <= 1'b0; m_wr <= 1'b0; m_burst <= 1'b0;
            m_n <= 1; m_iss <= 0; m_cmp <= 0;
            m_hwdata <= '0; m_hwstrb <= '0;
            for (int k = 0; k < BEATS; k++) m_fb[k] <= '0;
        end else if (m_wait) begin
            if (!Stall) m_wait <= 1'b0;
        end else if (!m_busy) begin
            if (m_req() && HREADY) begin
                m_busy   <= 1'b1;
                m_burst  <= Burst;
                m_n      <= Burst ? BEATS : 1;
                m_iss    <= 1;
                m_cmp    <= 0;
                m_wr     <= (BusRW == 2'b01);
                m_hwdata <= WriteData;
                m_hwstrb <= Burst ? 8'hFF : ByteMask;
            end
        end else if (HREADY) begin
            if (!m_wr) m_fb[m_cmp] <= HRDATA;
            m_cmp <= m_cmp + 1;
            if (m_iss < m_n) begin
                m_iss    <= m_iss + 1;
                m_hwdata <= WriteData;
                m_hwstrb <= m_burst ? 8'hFF : ByteMask;
            end
            if (m_cmp + 1 == m_n) begin
                m_busy <= 1'b0;
                m_wait <= Stall;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic          chk_en = 1'b0;
    logic [1:0]    e_tr;
    logic          e_bur, e_wr;
    int            e_beat;
    logic [PA-1:0] e_addr;

    always @(negedge HCLK) begin
        if (chk_en && !HRESET) begin
            if (m_busy) begin
                e_tr = (m_iss < m_n) ? 2'b11 : 2'b00;
                e_bur = m_burst; e_wr = m_wr; e_beat = m_iss;
            end else begin
                e_tr = (!m_wait && m_req()) ? 2'b10 : 2'b00;
                e_bur = Burst; e_wr = (BusRW == 2'b01); e_beat = 0;
            end
            e_addr = (e_tr == 2'b00) ? '0
                   : (e_bur ? ((Addr & ~PA'(32'h1F)) | PA'(e_beat * 8)) : Addr);
            chk("m_htrans", HTRANS, e_tr);
            chk("m_haddr", HADDR, e_addr);
            chk("m_hburst", HBURST, (e_tr == 2'b00) ? 3'b000 : (e_bur ? 3'b011 : 3'b000));
            chk("m_hsize", HSIZE, (e_tr == 2'b00) ? 3'b000 : (e_bur ? 3'b011 : Size));
            chk("m_hwrite", HWRITE, (e_tr != 2'b00) && e_wr);
            chk("m_busstall", BusStall, m_busy ? !((m_iss == m_n) && HREADY) : (!m_wait && m_req()));
            chk("m_committed", BusCommitted, m_busy);
            chk("m_writebeat", WriteBeat, m_busy ? m_iss : 0);
            chk("m_hwdata", HWDATA, m_hwdata);
            chk("m_hwstrb", HWSTRB, m_hwstrb);
            chk("m_fetchbuf", FetchBuffer, {m_fb[3], m_fb[2], m_fb[1], m_fb[0]});
        end
    end

    // ---------------- stimulus ----------------
    logic [63:0] tbase;
    int          cyc;
    logic        wfollow = 1'b0;

    task automatic step();
        @(posedge HCLK);
        #1;
        cyc++;
        HRDATA = tbase + 64'(cyc);
        if (wfollow) WriteData = wd(int'(WriteBeat));
    endtask

    task automatic new_test(input logic [63:0] b);
        tbase = b; cyc = 0; HRDATA = b;
    endtask

    localparam logic [63:0] T1 = 64'h1111_0000_0000_0000;
    localparam logic [63:0] T3 = 64'h3333_0000_0000_0000;
    localparam logic [63:0] T5 = 64'h5555_0000_0000_0000;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESET = 1'b1; HREADY = 1'b1; HRDATA = '0; Stall = 1'b0; Flush = 1'b0;
        BusRW = 2'b00; Burst = 1'b0; Addr = '0; Size = '0; ByteMask = '0; WriteData = '0;
        tbase = '0; cyc = 0;
        @(posedge HCLK); @(posedge HCLK); #1;
        HRESET = 1'b0;
        chk_en = 1'b1;

        // reset state
        @(negedge HCLK);
        chk("rst_htrans", HTRANS, 2'b00);
        chk("rst_busstall", BusStall, 1'b0);
        chk("rst_fetchbuf", FetchBuffer, 256'h0);
        chk("rst_hwdata", HWDATA, 64'h0);
        step();

        // 1: read burst, no wait states
        new_test(T1);
        BusRW = 2'b10; Burst = 1'b1; Addr = 56'h8000_0028;
        for (int c = 0; c < 5; c++) begin
            @(negedge HCLK);
            chk("t1_htrans", HTRANS, (c == 0) ? 2'b10 : ((c < 4) ? 2'b11 : 2'b00));
            chk("t1_busstall", BusStall, c < 4);
            if (c < 4) begin
                chk("t1_haddr", HADDR, 56'h8000_0020 + 56'(8 * c));
                chk("t1_hburst", HBURST, 3'b011);
            end
            step();
        end
        BusRW = 2'b00;
        @(negedge HCLK);
        chk("t1_fetchbuf", FetchBuffer, {T1 + 64'd4, T1 + 64'd3, T1 + 64'd2, T1 + 64'd1});
        step();

        // 2: single write
        BusRW = 2'b01; Burst = 1'b0; Addr = 56'h1004; Size = 3'b010;
        ByteMask = 8'hF0; WriteData = 64'hDEADBEEF_00000000;
        @(negedge HCLK);
        chk("t2_htrans", HTRANS, 2'b10);
        chk("t2_hburst", HBURST, 3'b000);
        chk("t2_hsize", HSIZE, 3'b010);
        chk("t2_haddr", HADDR, 56'h1004);
        step();
        BusRW = 2'b00; WriteData = '0;
        @(negedge HCLK);
        chk("t2_htrans_idle", HTRANS, 2'b00);
        chk("t2_hwdata", HWDATA, 64'hDEADBEEF_00000000);
        chk("t2_hwstrb", HWSTRB, 8'hF0);
        step();

        // 3: read burst with 3 wait states on the beat-2 data phase
        new_test(T3);
        BusRW = 2'b10; Burst = 1'b1; Addr = 56'h47;
        for (int c = 0; c < 8; c++) begin
            @(negedge HCLK);
            chk("t3_htrans", HTRANS, (c == 0) ? 2'b10 : ((c <= 6) ? 2'b11 : 2'b00));
            if (c <= 6) chk("t3_haddr", HADDR, 56'h40 + 56'(8 * ((c < 3) ? c : 3)));
            if (c == 5 || c == 6) chk("t3_slice2_hold", FetchBuffer[128 +: 64], T1 + 64'd3);
            if (c == 7) chk("t3_busstall_end", BusStall, 1'b0);
            step();
            HREADY = !((c + 1 >= 3) && (c + 1 <= 5));
        end
        BusRW = 2'b00;
        @(negedge HCLK);
        chk("t3_fetchbuf", FetchBuffer, {T3 + 64'd7, T3 + 64'd6, T3 + 64'd2, T3 + 64'd1});
        step();

        // 4a: flushed request never issues
        Flush = 1'b1; BusRW = 2'b10; Burst = 1'b1; Addr = 56'h500;
        for (int c = 0; c < 2; c++) begin
            @(negedge HCLK);
            chk("t4a_htrans", HTRANS, 2'b00);
            chk("t4a_busstall", BusStall, 1'b0);
            step();
        end

        // 4b: write burst, Flush raised after NONSEQ accepted
        new_test(64'h4444_0000_0000_0000);
        Flush = 1'b0; BusRW = 2'b01; Burst = 1'b1; Addr = 56'h1230;
        wfollow = 1'b1; WriteData = wd(0);
        for (int c = 0; c < 5; c++) begin
            @(negedge HCLK);
            chk("t4b_htrans", HTRANS, (c == 0) ? 2'b10 : ((c < 4) ? 2'b11 : 2'b00));
            chk("t4b_committed", BusCommitted, c >= 1);
            if (c < 4) chk("t4b_haddr", HADDR, 56'h1220 + 56'(8 * c));
            if (c >= 1) begin
                chk("t4b_hwdata", HWDATA, wd(c - 1));
                chk("t4b_hwstrb", HWSTRB, 8'hFF);
            end
            step();
            Flush = 1'b1;
        end
        BusRW = 2'b00; Flush = 1'b0; wfollow = 1'b0;

        // 5: Stall held across completion
        new_test(T5);
        BusRW = 2'b10; Burst = 1'b1; Addr = 56'h2000;
        for (int c = 0; c < 13; c++) begin
            @(negedge HCLK);
            chk("t5_htrans", HTRANS, (c == 0 || c == 8) ? 2'b10
                                   : ((c < 4 || (c > 8 && c < 12)) ? 2'b11 : 2'b00));
            if (c >= 5 && c <= 7) begin
                chk("t5_done_busstall", BusStall, 1'b0);
                chk("t5_done_committed", BusCommitted, 1'b0);
            end
            if (c == 8) chk("t5_reissue_addr", HADDR, 56'h2000);
            step();
            Stall = (c + 1 >= 2) && (c + 1 <= 6);
        end
        BusRW = 2'b00;
        @(negedge HCLK);
        chk("t5_fetchbuf", FetchBuffer, {T5 + 64'd12, T5 + 64'd11, T5 + 64'd10, T5 + 64'd9});
        step();

        // 6: reset in the middle of a write burst
        new_test(64'h6666_0000_0000_0000);
        BusRW = 2'b01; Burst = 1'b1; Addr = 56'h3000; wfollow = 1'b1; WriteData = wd(0);
        for (int c = 0; c < 9; c++) begin
            @(negedge HCLK);
            if (c == 3) begin
                chk("t6_htrans", HTRANS, 2'b00);
                chk("t6_busstall", BusStall, 1'b0);
                chk("t6_fetchbuf", FetchBuffer, 256'h0);
                chk("t6_hwdata", HWDATA, 64'h0);
                chk("t6_committed", BusCommitted, 1'b0);
            end
            if (c == 4) begin
                chk("t6_new_htrans", HTRANS, 2'b10);
                chk("t6_new_haddr", HADDR, 56'h3000);
            end
            if (c == 5) begin
                chk("t6_new_beat", WriteBeat, 3'd1);
                chk("t6_new_haddr1", HADDR, 56'h3008);
            end
            step();
            if (c + 1 == 2) begin HRESET = 1'b1; BusRW = 2'b00; wfollow = 1'b0; end
            if (c + 1 == 3) HRESET = 1'b0;
            if (c + 1 == 4) BusRW = 2'b10;
        end
        BusRW = 2'b00;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
